mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter onto a single-port TCM with 1-cycle synchronous read.
// Round-robin on conflicts, fixed one-cycle response latency, out-of-range accesses answered with error.
module mem_port_arbiter #(
  parameter int ADDR_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              mem_i_rd_i,
  input  logic [31:0]       mem_i_pc_i,
  output logic              mem_i_accept_o,
  output logic              mem_i_valid_o,
  output logic              mem_i_error_o,
  output logic [31:0]       mem_i_inst_o,
  input  logic [31:0]       mem_d_addr_i,
  input  logic [31:0]       mem_d_data_wr_i,
  input  logic              mem_d_rd_i,
  input  logic [3:0]        mem_d_wr_i,
  input  logic [10:0]       mem_d_req_tag_i,
  output logic              mem_d_accept_o,
  output logic              mem_d_ack_o,
  output logic              mem_d_error_o,
  output logic [31:0]       mem_d_data_rd_o,
  output logic [10:0]       mem_d_resp_tag_o,
  output logic              ram_en_o,
  output logic [3:0]        ram_we_o,
  output logic [ADDR_W-3:0] ram_addr_o,
  output logic [31:0]       ram_wdata_o,
  input  logic [31:0]       ram_rdata_i
);

  // Response FSM
  // state      | meaning
  // RESP_NONE  | nothing accepted last cycle, no response pulse
  // RESP_I_OK  | fetch accepted in range, return RAM word
  // RESP_I_ERR | fetch accepted out of range, error pulse
  // RESP_D_OK  | data accepted in range, ack (load data or 0 for store)
  // RESP_D_ERR | data accepted out of range, error ack
  typedef enum logic [2:0] {
    RESP_NONE,
    RESP_I_OK,
    RESP_I_ERR,
    RESP_D_OK,
    RESP_D_ERR
  } resp_e;

  resp_e       resp_q, resp_d;
  logic        last_grant_d_q;
  logic        resp_load_q;
  logic [10:0] tag_q;

  logic        d_req, d_store, conflict;
  logic        grant_i, grant_d;
  logic [31:0] sel_addr;
  logic        in_range;
  logic        unused_addr_lsb;

  assign d_req    = mem_d_rd_i | (|mem_d_wr_i);
  assign d_store  = |mem_d_wr_i;
  assign conflict = mem_i_rd_i & d_req;

  // last_grant_d_q=1 means data won the most recent conflict, so fetch wins the next one
  assign grant_i = rst_ni & mem_i_rd_i & (~d_req | last_grant_d_q);
  assign grant_d = rst_ni & d_req & ~grant_i;

  assign mem_i_accept_o = grant_i;
  assign mem_d_accept_o = grant_d;

  assign sel_addr        = grant_d ? mem_d_addr_i : mem_i_pc_i;
  assign in_range        = (sel_addr[31:ADDR_W] == '0);
  assign unused_addr_lsb = ^sel_addr[1:0];

  always_comb begin
    resp_d      = RESP_NONE;
    ram_en_o    = 1'b0;
    ram_we_o    = 4'b0000;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (grant_i) begin
      resp_d = in_range ? RESP_I_OK : RESP_I_ERR;
      if (in_range) begin
        ram_en_o   = 1'b1;
        ram_addr_o = sel_addr[ADDR_W-1:2];
      end
    end else if (grant_d) begin
      resp_d = in_range ? RESP_D_OK : RESP_D_ERR;
      if (in_range) begin
        ram_en_o    = 1'b1;
        ram_addr_o  = sel_addr[ADDR_W-1:2];
        ram_we_o    = d_store ? mem_d_wr_i : 4'b0000;
        ram_wdata_o = mem_d_data_wr_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_q <= RESP_NONE;
    end else begin
      resp_q <= resp_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_grant_d_q <= 1'b1;
      resp_load_q    <= 1'b0;
      tag_q          <= '0;
    end else begin
      if (conflict) begin
        last_grant_d_q <= grant_d;
      end
      if (grant_d) begin
        resp_load_q <= ~d_store;
        tag_q       <= mem_d_req_tag_i;
      end
    end
  end

  always_comb begin
    mem_i_valid_o   = 1'b0;
    mem_i_error_o   = 1'b0;
    mem_i_inst_o    = '0;
    mem_d_ack_o     = 1'b0;
    mem_d_error_o   = 1'b0;
    mem_d_data_rd_o = '0;
    case (resp_q)
      RESP_I_OK: begin
        mem_i_valid_o = 1'b1;
        mem_i_inst_o  = ram_rdata_i;
      end
      RESP_I_ERR: begin
        mem_i_valid_o = 1'b1;
        mem_i_error_o = 1'b1;
      end
      RESP_D_OK: begin
        mem_d_ack_o     = 1'b1;
        mem_d_data_rd_o = resp_load_q ? ram_rdata_i : 32'h0;
      end
      RESP_D_ERR: begin
        mem_d_ack_o   = 1'b1;
        mem_d_error_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_d_resp_tag_o = tag_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand sequences for conflicts/reset,
// and random traffic checked against a request-level reference model with its own memory image.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 16;
  localparam int WORDS  = 1 << (ADDR_W - 2);

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic              rst_ni;
  logic              mem_i_rd_i;
  logic [31:0]       mem_i_pc_i;
  logic              mem_i_accept_o, mem_i_valid_o, mem_i_error_o;
  logic [31:0]       mem_i_inst_o;
  logic [31:0]       mem_d_addr_i, mem_d_data_wr_i;
  logic              mem_d_rd_i;
  logic [3:0]        mem_d_wr_i;
  logic [10:0]       mem_d_req_tag_i;
  logic              mem_d_accept_o, mem_d_ack_o, mem_d_error_o;
  logic [31:0]       mem_d_data_rd_o;
  logic [10:0]       mem_d_resp_tag_o;
  logic              ram_en_o;
  logic [3:0]        ram_we_o;
  logic [ADDR_W-3:0] ram_addr_o;
  logic [31:0]       ram_wdata_o;
  logic [31:0]       ram_rdata_i;

  mem_port_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .mem_i_rd_i(mem_i_rd_i), .mem_i_pc_i(mem_i_pc_i),
    .mem_i_accept_o(mem_i_accept_o), .mem_i_valid_o(mem_i_valid_o),
    .mem_i_error_o(mem_i_error_o), .mem_i_inst_o(mem_i_inst_o),
    .mem_d_addr_i(mem_d_addr_i), .mem_d_data_wr_i(mem_d_data_wr_i),
    .mem_d_rd_i(mem_d_rd_i), .mem_d_wr_i(mem_d_wr_i), .mem_d_req_tag_i(mem_d_req_tag_i),
    .mem_d_accept_o(mem_d_accept_o), .mem_d_ack_o(mem_d_ack_o),
    .mem_d_error_o(mem_d_error_o), .mem_d_data_rd_o(mem_d_data_rd_o),
    .mem_d_resp_tag_o(mem_d_resp_tag_o),
    .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
  );

  // RAM attached to the DUT: read-before-write, one-cycle read latency
  logic [31:0] tb_ram [WORDS];
  always @(posedge clk_i) begin
    if (ram_en_o) begin
      ram_rdata_i <= tb_ram[ram_addr_o];
      for (int b = 0; b < 4; b++)
        if (ram_we_o[b]) tb_ram[ram_addr_o][8*b +: 8] <= ram_wdata_o[8*b +: 8];
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: request-level view of arbitration, responses and memory contents
  logic [31:0] model_mem [WORDS];
  bit          m_fetch_won_last;
  int          m_pend;          // 0 none, 1 fetch response, 2 data response
  bit          m_err;
  logic [31:0] m_data;
  logic [10:0] m_tag;

  logic        o_acc_i, o_acc_d, o_en, o_ivalid, o_dack, o_derr;
  logic [3:0]  o_we;
  logic [13:0] o_addr;
  logic [31:0] o_inst, o_ddata;
  logic [10:0] o_tag;

  task automatic model_reset();
    m_fetch_won_last = 1'b0;
    m_pend = 0;
    m_err = 1'b0;
    m_data = '0;
    m_tag = '0;
  endtask

  task automatic drive(input logic ird, input logic [31:0] pc, input logic drd,
                       input logic [3:0] dwr, input logic [31:0] daddr,
                       input logic [31:0] dwdata, input logic [10:0] tag);
    mem_i_rd_i = ird; mem_i_pc_i = pc; mem_d_rd_i = drd; mem_d_wr_i = dwr;
    mem_d_addr_i = daddr; mem_d_data_wr_i = dwdata; mem_d_req_tag_i = tag;
  endtask

  task automatic cycle();
    bit ireq, dreq, gi, gd, inr, is_store;
    logic [31:0] sel;
    int unsigned word;
    @(negedge clk_i);
    ireq = mem_i_rd_i;
    is_store = (mem_d_wr_i != 4'b0000);
    dreq = mem_d_rd_i || is_store;
    gi = ireq && (!dreq || !m_fetch_won_last);
    gd = dreq && !gi;
    sel = gd ? mem_d_addr_i : mem_i_pc_i;
    inr = (sel < (32'h1 << ADDR_W));
    word = (sel % (32'h1 << ADDR_W)) / 4;
    chk("accept_i", mem_i_accept_o, gi);
    chk("accept_d", mem_d_accept_o, gd);
    chk("ram_en", ram_en_o, (gi || gd) && inr);
    chk("ram_we", ram_we_o, (gd && inr && is_store) ? mem_d_wr_i : 4'b0000);
    if ((gi || gd) && inr) chk("ram_addr", ram_addr_o, word);
    if (gd && inr) chk("ram_wdata", ram_wdata_o, mem_d_data_wr_i);
    chk("i_valid", mem_i_valid_o, m_pend == 1);
    chk("i_error", mem_i_error_o, m_pend == 1 && m_err);
    chk("i_inst", mem_i_inst_o, (m_pend == 1) ? m_data : 32'h0);
    chk("d_ack", mem_d_ack_o, m_pend == 2);
    chk("d_error", mem_d_error_o, m_pend == 2 && m_err);
    chk("d_data", mem_d_data_rd_o, (m_pend == 2) ? m_data : 32'h0);
    chk("d_tag", mem_d_resp_tag_o, m_tag);
    o_acc_i = mem_i_accept_o; o_acc_d = mem_d_accept_o; o_en = ram_en_o; o_we = ram_we_o;
    o_addr = ram_addr_o; o_ivalid = mem_i_valid_o; o_inst = mem_i_inst_o;
    o_dack = mem_d_ack_o; o_derr = mem_d_error_o; o_ddata = mem_d_data_rd_o; o_tag = mem_d_resp_tag_o;
    @(posedge clk_i);
    if (ireq && dreq) m_fetch_won_last = gi;
    if (gi) begin
      m_pend = 1; m_err = !inr;
      m_data = inr ? model_mem[word] : 32'h0;
    end else if (gd) begin
      m_pend = 2; m_err = !inr;
      m_data = (inr && !is_store) ? model_mem[word] : 32'h0;
      if (inr && is_store)
        for (int b = 0; b < 4; b++)
          if (mem_d_wr_i[b]) model_mem[word][8*b +: 8] = mem_d_data_wr_i[8*b +: 8];
      m_tag = mem_d_req_tag_i;
    end else begin
      m_pend = 0;
    end
    #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, {mem_i_accept_o, mem_i_valid_o, mem_i_error_o, mem_i_inst_o,
             mem_d_accept_o, mem_d_ack_o, mem_d_error_o, mem_d_data_rd_o, mem_d_resp_tag_o,
             ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o}, '0);
  endtask

  task automatic apply_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_ni = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk_all_zero("reset_outputs");
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
  endtask

  typedef struct {
    logic        ird;   logic [31:0] pc;
    logic        drd;   logic [3:0]  dwr;
    logic [31:0] daddr; logic [31:0] dwdata; logic [10:0] tag;
    logic        e_acc_i, e_acc_d, e_en; logic [3:0] e_we; logic [13:0] e_addr;
    logic        e_ivalid; logic [31:0] e_inst;
    logic        e_dack, e_derr; logic [31:0] e_ddata; logic [10:0] e_tag;
  } vec_t;

  vec_t vecs [9];
  int   gpat [4];
  logic [31:0] rpc;
  logic [31:0] rda;

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      tb_ram[i]    = 32'hC0DE0000 + i;
      model_mem[i] = 32'hC0DE0000 + i;
    end
    ram_rdata_i = '0;

    //           ird pc        drd dwr      daddr         dwdata        tag     aI aD en we       addr    iv inst          dk de ddata         tag
    vecs[0] = '{1, 32'h0,     0, 4'b0000, 32'h0,       32'h0,        11'h0,   1, 0, 1, 4'b0000, 14'h0,  0, 32'h0,        0, 0, 32'h0,        11'h0};
    vecs[1] = '{1, 32'h4,     0, 4'b0000, 32'h0,       32'h0,        11'h0,   1, 0, 1, 4'b0000, 14'h1,  1, 32'hC0DE0000, 0, 0, 32'h0,        11'h0};
    vecs[2] = '{1, 32'h8,     0, 4'b0000, 32'h0,       32'h0,        11'h0,   1, 0, 1, 4'b0000, 14'h2,  1, 32'hC0DE0001, 0, 0, 32'h0,        11'h0};
    vecs[3] = '{0, 32'h0,     0, 4'b0011, 32'h100,     32'h12345678, 11'h5,   0, 1, 1, 4'b0011, 14'h40, 1, 32'hC0DE0002, 0, 0, 32'h0,        11'h0};
    vecs[4] = '{0, 32'h0,     1, 4'b0000, 32'h100,     32'h0,        11'h6,   0, 1, 1, 4'b0000, 14'h40, 0, 32'h0,        1, 0, 32'h0,        11'h5};
    vecs[5] = '{0, 32'h0,     1, 4'b0000, 32'h10000,   32'h0,        11'h7FF, 0, 1, 0, 4'b0000, 14'h0,  0, 32'h0,        1, 0, 32'hC0DE5678, 11'h6};
    vecs[6] = '{0, 32'h0,     1, 4'b1100, 32'h104,     32'hAABBCCDD, 11'h12,  0, 1, 1, 4'b1100, 14'h41, 0, 32'h0,        1, 1, 32'h0,        11'h7FF};
    vecs[7] = '{0, 32'h0,     0, 4'b0000, 32'h0,       32'h0,        11'h0,   0, 0, 0, 4'b0000, 14'h0,  0, 32'h0,        1, 0, 32'h0,        11'h12};
    vecs[8] = '{0, 32'h0,     0, 4'b0000, 32'h0,       32'h0,        11'h0,   0, 0, 0, 4'b0000, 14'h0,  0, 32'h0,        0, 0, 32'h0,        11'h12};

    rst_ni = 1'b0;
    apply_reset();

    for (int v = 0; v < 9; v++) begin
      drive(vecs[v].ird, vecs[v].pc, vecs[v].drd, vecs[v].dwr, vecs[v].daddr, vecs[v].dwdata, vecs[v].tag);
      cycle();
      chk($sformatf("vec%0d_accept", v), {o_acc_i, o_acc_d}, {vecs[v].e_acc_i, vecs[v].e_acc_d});
      chk($sformatf("vec%0d_ram", v), {o_en, o_we}, {vecs[v].e_en, vecs[v].e_we});
      if (vecs[v].e_en) chk($sformatf("vec%0d_addr", v), o_addr, vecs[v].e_addr);
      chk($sformatf("vec%0d_irsp", v), {o_ivalid, o_inst}, {vecs[v].e_ivalid, vecs[v].e_inst});
      chk($sformatf("vec%0d_drsp", v), {o_dack, o_derr, o_ddata, o_tag},
          {vecs[v].e_dack, vecs[v].e_derr, vecs[v].e_ddata, vecs[v].e_tag});
    end

    // Conflict round-robin: losers hold their request until accepted
    apply_reset();
    drive(1, 32'h20, 1, 4'b0000, 32'h200, 32'h0, 11'h1);
    cycle(); gpat[0] = o_acc_i;
    drive(1, 32'h24, 1, 4'b0000, 32'h200, 32'h0, 11'h1);
    cycle(); gpat[1] = o_acc_i;
    drive(1, 32'h24, 1, 4'b0000, 32'h204, 32'h0, 11'h2);
    cycle(); gpat[2] = o_acc_i;
    drive(1, 32'h28, 1, 4'b0000, 32'h204, 32'h0, 11'h2);
    cycle(); gpat[3] = o_acc_i;
    chk("rr_grants_IDID", {gpat[0][0], gpat[1][0], gpat[2][0], gpat[3][0]}, 4'b1010);
    // Lone fetch must not move the round-robin pointer: data won last conflict, fetch wins next
    drive(1, 32'h2C, 0, 4'b0000, 32'h0, 32'h0, 11'h0);
    cycle();
    drive(1, 32'h30, 1, 4'b0000, 32'h208, 32'h0, 11'h3);
    cycle();
    chk("rr_after_lone", {o_acc_i, o_acc_d}, 2'b10);

    // Reset asserted right after a fetch accept drops the response
    apply_reset();
    drive(0, 0, 1, 4'b0000, 32'h300, 0, 11'h4);
    cycle();
    drive(1, 32'h40, 0, 4'b0000, 32'h0, 32'h0, 11'h0);
    cycle();
    chk("pre_rst_fetch_acc", o_acc_i, 1'b1);
    rst_ni = 1'b0;
    model_reset();
    #1;
    chk_all_zero("midcycle_reset");
    @(negedge clk_i);
    chk_all_zero("held_reset");
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    drive(0, 0, 0, 4'b0000, 0, 0, 0);
    cycle();
    chk("no_valid_after_rst", {o_ivalid, o_dack}, 2'b00);
    drive(1, 32'h44, 1, 4'b0000, 32'h300, 32'h0, 11'h9);
    cycle();
    chk("rst_conflict_fetch", {o_acc_i, o_acc_d}, 2'b10);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rpc = ($urandom_range(0, 63) << 2) | ($urandom & 32'h3);
      rda = ($urandom_range(0, 63) << 2) | ($urandom & 32'h3);
      if ($urandom_range(0, 15) == 0) rpc = rpc | ($urandom_range(1, 65535) << 16);
      if ($urandom_range(0, 15) == 0) rda = rda | ($urandom_range(1, 65535) << 16);
      drive($urandom_range(0, 9) < 6, rpc, $urandom_range(0, 1) == 1,
            ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000,
            rda, $urandom, 11'($urandom));
      cycle();
    end
    drive(0, 0, 0, 4'b0000, 0, 0, 0);
    cycle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
